branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: resolves br/jal/jalr ops one cycle after acceptance and
// drives a multi-cycle pipeline flush on mispredict.
// Optional feature macro: BRANCH_STATS_EN adds the br/mispredict counters.
// Handshake: an op transfers on a rising edge where valid_w_i_h and
// ready_w_o_h are both 1; ready never depends on valid, and the result
// appears as a single-cycle valid_w_o_h pulse on the following cycle.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int STAT_W       = 32
) (
  input  logic        clk_w_i,
  input  logic        rst_w_i_h,
  input  logic        valid_w_i_h,
  output logic        ready_w_o_h,
  input  logic        br_w_i_h,
  input  logic        jal_w_i_h,
  input  logic        jalr_w_i_h,
  input  logic [2:0]  funct3_w_i,
  input  logic [31:0] pc_w_i,
  input  logic [31:0] imm_w_i,
  input  logic [31:0] rs1_w_i,
  input  logic        pred_taken_w_i_h,
  input  logic        eq_w_i_h,
  input  logic        lts_w_i_h,
  input  logic        ltu_w_i_h,
  input  logic        gtes_w_i_h,
  input  logic        gteu_w_i_h,
  output logic        valid_w_o_h,
  output logic        taken_w_o_h,
  output logic [31:0] target_w_o,
  output logic [31:0] link_w_o,
  output logic [31:0] redirect_pc_w_o,
  output logic        flush_w_o_h,
  output logic        illegal_w_o_h,
  output logic        misalign_w_o_h,
`ifdef BRANCH_STATS_EN
  output logic [STAT_W-1:0] br_cnt_w_o,
  output logic [STAT_W-1:0] mispred_cnt_w_o,
`endif
  output logic        state_dbg_w_o
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || STAT_W < 1) begin : g_param_check
    $error("branch_resolve: FLUSH_CYCLES must be 1..15 and STAT_W >= 1");
  end

  typedef enum logic { IDLE = 1'b0, FLUSH = 1'b1 } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_d;

  logic        accept;
  logic        kind_jalr, kind_jal, kind_br;
  logic        cond, bad_f3, taken_c, mispred_c;
  logic [31:0] target_c, link_c, jalr_sum;

  assign ready_w_o_h   = !rst_w_i_h && (state_q == IDLE);
  assign accept        = valid_w_i_h && ready_w_o_h;
  assign state_dbg_w_o = (state_q == FLUSH);

  // Decode op kind, branch condition, target and mispredict for the offered op
  always_comb begin
    kind_jalr = jalr_w_i_h;
    kind_jal  = jal_w_i_h && !jalr_w_i_h;
    kind_br   = br_w_i_h && !jal_w_i_h && !jalr_w_i_h;
    cond      = 1'b0;
    bad_f3    = 1'b0;
    case (funct3_w_i)
      3'b000:  cond = eq_w_i_h;
      3'b001:  cond = !eq_w_i_h;
      3'b100:  cond = lts_w_i_h;
      3'b101:  cond = gtes_w_i_h;
      3'b110:  cond = ltu_w_i_h;
      3'b111:  cond = gteu_w_i_h;
      default: bad_f3 = 1'b1;
    endcase
    jalr_sum  = rs1_w_i + imm_w_i;
    link_c    = pc_w_i + 32'd4;
    target_c  = kind_jalr ? {jalr_sum[31:1], 1'b0} : (pc_w_i + imm_w_i);
    taken_c   = kind_jalr || kind_jal || (kind_br && cond);
    mispred_c = kind_jalr
             || (kind_jal && !pred_taken_w_i_h)
             || (kind_br && (taken_c != pred_taken_w_i_h));
  end

  // Next-state logic for the IDLE/FLUSH machine and its flush counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_w_o_h;
    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (accept && mispred_c) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        flush_d = 1'b0;
      end
    endcase
  end

  // State register and flush output
  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      flush_w_o_h <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_w_o_h <= flush_d;
    end
  end

  // Result registers: captured on acceptance and held so redirect stays stable during flush
  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      valid_w_o_h     <= 1'b0;
      taken_w_o_h     <= 1'b0;
      target_w_o      <= 32'h0;
      link_w_o        <= 32'h0;
      redirect_pc_w_o <= 32'h0;
      illegal_w_o_h   <= 1'b0;
      misalign_w_o_h  <= 1'b0;
    end else begin
      valid_w_o_h   <= accept;
      illegal_w_o_h <= accept && kind_br && bad_f3;
      if (accept) begin
        taken_w_o_h     <= taken_c;
        target_w_o      <= target_c;
        link_w_o        <= link_c;
        redirect_pc_w_o <= taken_c ? target_c : link_c;
        misalign_w_o_h  <= taken_c && target_c[1];
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Statistics: resolved br ops and mispredicts, wrapping at 2^STAT_W
  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      br_cnt_w_o      <= '0;
      mispred_cnt_w_o <= '0;
    end else if (accept) begin
      if (kind_br)   br_cnt_w_o      <= br_cnt_w_o + 1'b1;
      if (mispred_c) mispred_cnt_w_o <= mispred_cnt_w_o + 1'b1;
    end
  end
`endif

endmodule
